// File: rtl/seven_seg_scan_capture_if.sv
// Seven-segment scan bus seen from the capture side.
// The display lines flow in, and the decoded display image flows back out.
interface seven_seg_scan_capture_if #(
  parameter int unsigned DIGITS = 8
);
  logic [DIGITS-1:0]   an_n;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   digit_valid;
  logic                frame_done;
  logic                code_error;
  logic [2:0]          err_digit;

  modport master (
    output an_n, seg_n, dp_n,
    input  digits, dp, digit_valid, frame_done, code_error, err_digit
  );

  modport slave (
    input  an_n, seg_n, dp_n,
    output digits, dp, digit_valid, frame_done, code_error, err_digit
  );
endinterface

// File: rtl/seven_seg_scan_capture.sv
// Multiplexed seven-segment bus monitor: synchronizes, debounces scan transitions,
// decodes stable patterns back to BCD and keeps a per-digit image of the display.
module seven_seg_scan_capture #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_seg_scan_capture_if.slave bus
);

  localparam int unsigned VW = DIGITS + 8;

  logic [VW-1:0]       sync1_q, sync1_d;
  logic [VW-1:0]       sync2_q, sync2_d;
  logic [VW-1:0]       prev_q, prev_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                accept;

  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                frame_done_q, frame_done_d;
  logic                code_error_q, code_error_d;
  logic [2:0]          err_digit_q, err_digit_d;

  logic [DIGITS-1:0]   an_act;
  logic [6:0]          seg_act;
  logic                dp_act;
  logic [3:0]          act_cnt;
  logic [2:0]          low_idx;
  logic                low_found;
  logic                dec_legal;
  logic [3:0]          dec_code;
  logic [DIGITS-1:0]   seen_next;

  // Stability filter: a pattern is accepted once, after it has held for STABLE_CYCLES synced cycles.
  always_comb begin
    sync1_d = {bus.an_n, bus.seg_n, bus.dp_n};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    accept  = 1'b0;
    if (sync2_q != prev_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
      if (armed_q && (cnt_d == 8'(STABLE_CYCLES - 1))) begin
        accept  = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  assign an_act  = ~sync2_q[VW-1:8];
  assign seg_act = ~sync2_q[7:1];
  assign dp_act  = ~sync2_q[0];

  always_comb begin
    act_cnt   = '0;
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (an_act[i]) begin
        act_cnt = act_cnt + 4'd1;
        if (!low_found) begin
          low_idx   = 3'(i);
          low_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    dec_legal = 1'b1;
    dec_code  = 4'hF;
    case (seg_act)
      7'b1111110: dec_code = 4'd0;
      7'b0110000: dec_code = 4'd1;
      7'b1101101: dec_code = 4'd2;
      7'b1111001: dec_code = 4'd3;
      7'b0110011: dec_code = 4'd4;
      7'b1011011: dec_code = 4'd5;
      7'b0011111: dec_code = 4'd6;
      7'b1110000: dec_code = 4'd7;
      7'b1111111: dec_code = 4'd8;
      7'b1110011: dec_code = 4'd9;
      7'b0000001: dec_code = 4'd10;
      7'b0000000: dec_code = 4'hF;
      default:    dec_legal = 1'b0;
    endcase
  end

  // An illegal pattern still marks the digit as scanned, so a bad last digit completes the frame.
  always_comb begin
    digits_d     = digits_q;
    dp_d         = dp_q;
    valid_d      = valid_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    code_error_d = 1'b0;
    err_digit_d  = err_digit_q;
    seen_next    = seen_q | an_act;
    if (accept && (act_cnt > 4'd1)) begin
      code_error_d = 1'b1;
      err_digit_d  = low_idx;
    end else if (accept && (act_cnt == 4'd1)) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (an_act[i]) begin
          if (dec_legal) begin
            digits_d[4*i +: 4] = dec_code;
            dp_d[i]            = dp_act;
            valid_d[i]         = 1'b1;
          end else begin
            valid_d[i]         = 1'b0;
          end
        end
      end
      if (!dec_legal) begin
        code_error_d = 1'b1;
        err_digit_d  = low_idx;
      end
      if (&seen_next) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d       = seen_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      prev_q       <= '1;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      digits_q     <= '1;
      dp_q         <= '0;
      valid_q      <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      code_error_q <= 1'b0;
      err_digit_q  <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      code_error_q <= code_error_d;
      err_digit_q  <= err_digit_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.dp          = dp_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.code_error  = code_error_q;
  assign bus.err_digit   = err_digit_q;

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Scoreboard bench for seven_seg_scan_capture: each held pattern queues the expected
// display image and pulses, and a monitor compares them on the predicted cycle.
module tb_seven_seg_scan_capture;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned STABLE = 4;
  localparam int          LAT    = STABLE + 2;

  typedef struct {
    int         at;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  valid;
    logic [2:0]  edig;
    logic        cerr;
    logic        fdone;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   fd_count = 0;
  bit   mon_en   = 1'b0;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] m_digits;
  logic [7:0]  m_dp;
  logic [7:0]  m_valid;
  logic [7:0]  m_seen;
  logic [2:0]  m_edig;

  seven_seg_scan_capture_if #(.DIGITS(DIGITS)) bus ();

  seven_seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0:  return 7'b1111110;
      1:  return 7'b0110000;
      2:  return 7'b1101101;
      3:  return 7'b1111001;
      4:  return 7'b0110011;
      5:  return 7'b1011011;
      6:  return 7'b0011111;
      7:  return 7'b1110000;
      8:  return 7'b1111111;
      9:  return 7'b1110011;
      10: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    m_digits  = '1;
    m_dp      = '0;
    m_valid   = '0;
    m_seen    = '0;
    m_edig    = '0;
    cur.at     = 0;
    cur.digits = m_digits;
    cur.dp     = m_dp;
    cur.valid  = m_valid;
    cur.edig   = m_edig;
    cur.cerr   = 1'b0;
    cur.fdone  = 1'b0;
    sb_q.delete();
  endtask

  // Drive one bus pattern; code = -1 marks a pattern that must decode as illegal.
  task automatic drive(input logic [7:0] an_n_v, input logic [6:0] seg_ah,
                       input logic dp_n_v, input int code, input bit held);
    exp_t e;
    int   nact;
    int   low;
    @(negedge clk);
    bus.an_n  = an_n_v;
    bus.seg_n = ~seg_ah;
    bus.dp_n  = dp_n_v;
    nact = 0;
    low  = -1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!an_n_v[i]) begin
        nact++;
        if (low < 0) low = i;
      end
    end
    if (!held || nact == 0) return;
    e.at    = cyc + LAT;
    e.cerr  = 1'b0;
    e.fdone = 1'b0;
    if (nact > 1) begin
      e.cerr = 1'b1;
      m_edig = 3'(low);
    end else begin
      if (code >= 0) begin
        m_digits[4*low +: 4] = 4'(code);
        m_dp[low]            = ~dp_n_v;
        m_valid[low]         = 1'b1;
      end else begin
        e.cerr       = 1'b1;
        m_edig       = 3'(low);
        m_valid[low] = 1'b0;
      end
      m_seen[low] = 1'b1;
      if (&m_seen) begin
        e.fdone = 1'b1;
        m_seen  = '0;
      end
    end
    e.digits = m_digits;
    e.dp     = m_dp;
    e.valid  = m_valid;
    e.edig   = m_edig;
    sb_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t        e;
    logic [52:0] obs;
    logic [52:0] expv;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (bus.frame_done === 1'b1) fd_count++;
      if (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
        e = sb_q.pop_front();
        if (e.at != cyc) begin
          n_checks++; n_fail++;
          $display("FAIL sb_timing: entry due at cycle %0d seen at cycle %0d", e.at, cyc);
        end
        n_checks++;
        if (bus.digits !== e.digits) begin
          n_fail++; $display("FAIL sb_digits @%0d: got %h expected %h", cyc, bus.digits, e.digits);
        end
        n_checks++;
        if (bus.dp !== e.dp) begin
          n_fail++; $display("FAIL sb_dp @%0d: got %h expected %h", cyc, bus.dp, e.dp);
        end
        n_checks++;
        if (bus.digit_valid !== e.valid) begin
          n_fail++; $display("FAIL sb_valid @%0d: got %h expected %h", cyc, bus.digit_valid, e.valid);
        end
        n_checks++;
        if (bus.code_error !== e.cerr) begin
          n_fail++; $display("FAIL sb_code_error @%0d: got %b expected %b", cyc, bus.code_error, e.cerr);
        end
        n_checks++;
        if (bus.err_digit !== e.edig) begin
          n_fail++; $display("FAIL sb_err_digit @%0d: got %0d expected %0d", cyc, bus.err_digit, e.edig);
        end
        n_checks++;
        if (bus.frame_done !== e.fdone) begin
          n_fail++; $display("FAIL sb_frame_done @%0d: got %b expected %b", cyc, bus.frame_done, e.fdone);
        end
        cur = e;
      end else begin
        obs  = {bus.digits, bus.dp, bus.digit_valid, bus.err_digit, bus.code_error, bus.frame_done};
        expv = {cur.digits, cur.dp, cur.valid, cur.edig, 1'b0, 1'b0};
        n_checks++;
        if (obs !== expv) begin
          n_fail++; $display("FAIL idle_state @%0d: got %h expected %h", cyc, obs, expv);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.digits !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_digits: got %h expected ffffffff", bus.digits); end
    n_checks++;
    if (bus.digit_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid: got %h expected 00", bus.digit_valid); end
    n_checks++;
    if (bus.dp !== 8'h00) begin n_fail++; $display("FAIL reset_dp: got %h expected 00", bus.dp); end
    n_checks++;
    if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    n_checks++;
    if (bus.code_error !== 1'b0) begin n_fail++; $display("FAIL reset_code_error: got %b expected 0", bus.code_error); end
    n_checks++;
    if (bus.err_digit !== 3'd0) begin n_fail++; $display("FAIL reset_err_digit: got %0d expected 0", bus.err_digit); end
    release_reset();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_full_scan();
    int fd0;
    fd0 = fd_count;
    for (int d = 0; d < 8; d++) begin
      drive(~(8'h01 << d), seg_of(d), (d == 3) ? 1'b0 : 1'b1, d, 1'b1);
      repeat (9) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.digits !== 32'h7654_3210) begin n_fail++; $display("FAIL scan_digits: got %h expected 76543210", bus.digits); end
    n_checks++;
    if (bus.dp !== 8'h08) begin n_fail++; $display("FAIL scan_dp: got %h expected 08", bus.dp); end
    n_checks++;
    if (bus.digit_valid !== 8'hFF) begin n_fail++; $display("FAIL scan_valid: got %h expected ff", bus.digit_valid); end
    n_checks++;
    if (fd_count - fd0 !== 1) begin n_fail++; $display("FAIL scan_frame_count: got %0d expected 1", fd_count - fd0); end
  endtask

  task automatic test_latency_glitch();
    int n;
    drive(8'b1111_1011, seg_of(8), 1'b1, 8, 1'b0);
    repeat (2) @(negedge clk);
    drive(8'b1111_1011, seg_of(9), 1'b1, 9, 1'b1);
    n = cyc;
    repeat (LAT - 1) @(negedge clk);
    n_checks++;
    if (bus.digits[11:8] !== 4'd2) begin
      n_fail++; $display("FAIL latency_early @%0d: got %0d expected 2", cyc - n, bus.digits[11:8]);
    end
    @(negedge clk);
    n_checks++;
    if (bus.digits[11:8] !== 4'd9) begin
      n_fail++; $display("FAIL latency_on_time @%0d: got %0d expected 9", cyc - n, bus.digits[11:8]);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_illegal();
    drive(8'b1101_1111, 7'b1000001, 1'b0, -1, 1'b1);
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.digits[23:20] !== 4'd5) begin n_fail++; $display("FAIL illegal_code_held: got %0d expected 5", bus.digits[23:20]); end
    n_checks++;
    if (bus.digit_valid[5] !== 1'b0) begin n_fail++; $display("FAIL illegal_valid: got %b expected 0", bus.digit_valid[5]); end
    n_checks++;
    if (bus.err_digit !== 3'd5) begin n_fail++; $display("FAIL illegal_err_digit: got %0d expected 5", bus.err_digit); end
  endtask

  task automatic test_anode_faults();
    drive(8'b1111_0101, seg_of(3), 1'b1, 3, 1'b1);
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.err_digit !== 3'd1) begin n_fail++; $display("FAIL multi_anode_err_digit: got %0d expected 1", bus.err_digit); end
    n_checks++;
    if (bus.digits !== m_digits) begin n_fail++; $display("FAIL multi_anode_digits: got %h expected %h", bus.digits, m_digits); end
    drive(8'hFF, seg_of(8), 1'b0, 8, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    for (int d = 0; d < 4; d++) begin
      drive(~(8'h01 << d), seg_of(d + 1), 1'b1, d + 1, 1'b1);
      repeat (9) @(negedge clk);
    end
    drive(8'hFF, 7'b1111111, 1'b1, 0, 1'b1);
    repeat (10) @(negedge clk);
    do_reset();
    n_checks++;
    if (bus.digits !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL midreset_digits: got %h expected ffffffff", bus.digits); end
    release_reset();
    fd0 = fd_count;
    for (int d = 0; d < 8; d++) begin
      drive(~(8'h01 << d), seg_of(10), 1'b1, 10, 1'b1);
      repeat (9) @(negedge clk);
      if (d < 7) begin
        n_checks++;
        if (fd_count != fd0) begin n_fail++; $display("FAIL dash_early_frame: got %0d pulses after digit %0d expected 0", fd_count - fd0, d); end
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.digits !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL dash_digits: got %h expected aaaaaaaa", bus.digits); end
    n_checks++;
    if (fd_count - fd0 !== 1) begin n_fail++; $display("FAIL dash_frame_count: got %0d expected 1", fd_count - fd0); end
  endtask

  initial begin
    bus.an_n  = '1;
    bus.seg_n = '1;
    bus.dp_n  = 1'b1;
    model_reset();
    fork
      monitor();
    join_none
    test_reset();
    test_full_scan();
    test_latency_glitch();
    test_illegal();
    test_anode_faults();
    test_reset_mid_frame();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
